// File: rtl/sub_pkg.sv
// Shared types and helpers for the serial subtractor datapath.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // The counter must hold every value 0..steps.
    function automatic int cnt_width(input int steps);
        return $clog2(steps + 1);
    endfunction

endpackage

// File: rtl/sub_digit.sv
// DIGIT-bit combinational ripple subtract slice: {bout, diff} = a - b - bin.
module sub_digit #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bin,
    output logic [DIGIT-1:0] diff,
    output logic             bout
);

    always_comb begin
        logic br;
        br   = bin;
        diff = '0;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            diff[i] = a[i] ^ b[i] ^ br;
            br      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
        end
        bout = br;
    end

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: DIFF = A - B - BIN, DIGIT bits per clock, borrow carried
// between cycles in a register; valid/ready handshake on both sides.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int STEPS = (DIGIT > 0) ? WIDTH / DIGIT : 1;
    localparam int CW    = cnt_width(STEPS);

    if (DIGIT <= 0 || DIGIT > WIDTH || ((DIGIT > 0) ? (WIDTH % DIGIT) : 1) != 0) begin : g_bad_params
        $error("serial_subtractor: WIDTH must be a non-zero multiple of DIGIT");
    end

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             brw;
    logic             a_msb;
    logic             ovf_cand;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] sd;
    logic             sbout;
    logic             accept;

    sub_digit #(.DIGIT(DIGIT)) u_digit (
        .a    (sa[DIGIT-1:0]),
        .b    (sb[DIGIT-1:0]),
        .bin  (brw),
        .diff (sd),
        .bout (sbout)
    );

    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            brw       <= 1'b0;
            a_msb     <= 1'b0;
            ovf_cand  <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            diff      <= '0;
            borrow    <= 1'b0;
            ovf       <= 1'b0;
        end else if (accept) begin
            // Covers both the idle start and the back-to-back start from DONE.
            state     <= RUN;
            sa        <= a;
            sb        <= b;
            brw       <= bin;
            a_msb     <= a[WIDTH-1];
            ovf_cand  <= signed_mode && (a[WIDTH-1] != b[WIDTH-1]);
            cnt       <= '0;
            out_valid <= 1'b0;
            borrow    <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    sa   <= sa >> DIGIT;
                    sb   <= sb >> DIGIT;
                    diff <= (WIDTH'(sd) << (WIDTH - DIGIT)) | (diff >> DIGIT);
                    brw  <= sbout;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(STEPS - 1)) begin
                        // The slice output on the last step is the final diff MSB.
                        state     <= DONE;
                        out_valid <= 1'b1;
                        borrow    <= sbout;
                        ovf       <= ovf_cand && (sd[DIGIT-1] != a_msb);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: four instances (DIGIT=2,1,4,8) driven in lockstep.
module tb_serial_subtractor;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic       bin;
    logic       sm;
    logic [7:0] a;
    logic [7:0] b;
    logic       ir [N];
    logic       ov [N];
    logic       bw [N];
    logic       of [N];
    logic [7:0] df [N];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic int digit_of(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        serial_subtractor #(.WIDTH(8), .DIGIT(digit_of(g))) u_dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (in_valid),
            .in_ready    (ir[g]),
            .a           (a),
            .b           (b),
            .bin         (bin),
            .signed_mode (sm),
            .out_valid   (ov[g]),
            .out_ready   (out_ready),
            .diff        (df[g]),
            .borrow      (bw[g]),
            .ovf         (of[g])
        );
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic       sm;
        logic [7:0] d;
        logic       bw;
        logic       of;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s digit=%0d actual=%0h required=%0h", name, digit_of(g), act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic vec_t model(input logic [7:0] xa, input logic [7:0] xb, input logic xbin, input logic xsm);
        vec_t v;
        int   ua, ub, sa, sb, ur, sr;
        ua = int'(xa);
        ub = int'(xb);
        sa = int'($signed(xa));
        sb = int'($signed(xb));
        ur = ua - ub - int'(xbin);
        sr = sa - sb - int'(xbin);
        v.a   = xa;
        v.b   = xb;
        v.bin = xbin;
        v.sm  = xsm;
        v.d   = 8'(ur);
        v.bw  = (ur < 0);
        v.of  = xsm && (sr < -128 || sr > 127);
        return v;
    endfunction

    task automatic apply(input vec_t v);
        a        = v.a;
        b        = v.b;
        bin      = v.bin;
        sm       = v.sm;
        in_valid = 1'b1;
    endtask

    // Drive one operation into all idle instances and check results and latency.
    task automatic do_op(input vec_t v);
        int lat [N];
        for (int g = 0; g < N; g++) begin
            lat[g] = 0;
            chk("in_ready_idle", g, 32'(ir[g]), 32'd1);
        end
        apply(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a   = 8'($urandom);
        b   = 8'($urandom);
        bin = 1'($urandom);
        sm  = ~v.sm;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            for (int g = 0; g < N; g++)
                if (ov[g] && lat[g] == 0) lat[g] = c;
            if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0 && lat[3] != 0) break;
        end
        for (int g = 0; g < N; g++) begin
            chk("latency", g, 32'(lat[g]), 32'(8 / digit_of(g)));
            chk("diff", g, 32'(df[g]), 32'(v.d));
            chk("borrow", g, 32'(bw[g]), 32'(v.bw));
            chk("ovf", g, 32'(of[g]), 32'(v.of));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int g = 0; g < N; g++) chk("out_valid_drop", g, 32'(ov[g]), 32'd0);
    endtask

    initial begin
        vec_t v, w;

        tbl[0] = '{8'h35, 8'h12, 1'b0, 1'b0, 8'h23, 1'b0, 1'b0};
        tbl[1] = '{8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0};
        tbl[2] = '{8'h10, 8'h0F, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1};
        tbl[4] = '{8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0};
        tbl[5] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0; sm = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) begin
            chk("rst_out_valid", g, 32'(ov[g]), 32'd0);
            chk("rst_diff", g, 32'(df[g]), 32'd0);
            chk("rst_borrow", g, 32'(bw[g]), 32'd0);
            chk("rst_ovf", g, 32'(of[g]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) do_op(tbl[i]);

        for (int i = 0; i < 40; i++)
            do_op(model(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom)));

        // Stall with out_ready low, then back-to-back accept from DONE.
        v = model(8'h5A, 8'hC3, 1'b1, 1'b1);
        w = model(8'h01, 8'h02, 1'b0, 1'b0);
        apply(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        a = 8'h11; b = 8'h22; bin = 1'b0; sm = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            for (int g = 0; g < N; g++) begin
                chk("stall_out_valid", g, 32'(ov[g]), 32'd1);
                chk("stall_diff", g, 32'(df[g]), 32'(v.d));
                chk("stall_flags", g, 32'({bw[g], of[g]}), 32'({v.bw, v.of}));
                chk("stall_in_ready", g, 32'(ir[g]), 32'd0);
            end
        end
        apply(w);
        out_ready = 1'b1;
        #1;
        for (int g = 0; g < N; g++) chk("b2b_in_ready", g, 32'(ir[g]), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        for (int g = 0; g < N; g++) begin
            chk("b2b_running", g, 32'(ov[g]), 32'd0);
            chk("b2b_busy", g, 32'(ir[g]), 32'd0);
        end
        repeat (8) @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) begin
            chk("b2b_valid", g, 32'(ov[g]), 32'd1);
            chk("b2b_diff", g, 32'(df[g]), 32'(w.d));
            chk("b2b_borrow", g, 32'(bw[g]), 32'(w.bw));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset two cycles into a run aborts it with no later result.
        apply(model(8'hAA, 8'h55, 1'b0, 1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        for (int g = 0; g < N; g++) begin
            chk("abort_out_valid", g, 32'(ov[g]), 32'd0);
            chk("abort_diff", g, 32'(df[g]), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int g = 0; g < N; g++) chk("abort_in_ready", g, 32'(ir[g]), 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            for (int g = 0; g < N; g++) chk("abort_no_stale", g, 32'(ov[g]), 32'd0);
        end

        do_op(model(8'h35, 8'h12, 1'b0, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
